// File: rtl/cordic_req_ctrl.sv
// Request controller in front of the CORDIC sin/cos engine: angle FIFO, one-at-a-time issue,
// held result register, sticky error flags. Define CORDIC_REQ_TIMEOUT_EN to enable the WAIT watchdog.
module cordic_req_ctrl #(
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    input  logic        rd_en,
    output logic [31:0] res_data,
    output logic        res_valid,
    output logic        busy,
    output logic        overflow,
    output logic        timeout,
    input  logic        clr_err,
    output logic [15:0] cnt_done,
    output logic        cord_start,
    output logic [31:0] cord_angle,
    input  logic [15:0] cord_cos,
    input  logic [15:0] cord_sin,
    input  logic        cord_valid
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop, empty;
    logic          latch_res, ack;

    assign empty = (count == '0);
    // A full FIFO rejects writes even when a pop frees a slot on the same edge.
    assign push  = wr_en && !wr_full;
    assign pop   = (state == IDLE) && !empty;
    assign busy  = (state != IDLE) || !empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

`ifdef CORDIC_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          to_fire;
`endif

    always_comb begin
        state_nxt  = state;
        latch_res  = 1'b0;
        ack        = 1'b0;
        cord_start = 1'b0;
`ifdef CORDIC_REQ_TIMEOUT_EN
        to_fire    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                cord_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (cord_valid) begin
                    latch_res = 1'b1;
                    state_nxt = HOLD;
                end
`ifdef CORDIC_REQ_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                    to_fire   = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            HOLD: begin
                if (rd_en && res_valid) begin
                    ack       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wr_full    <= 1'b0;
            cord_angle <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            cnt_done   <= '0;
            overflow   <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            wr_full <= (count_nxt == CW'(QDEPTH));
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                cord_angle <= mem[rd_ptr];
            end
            if (latch_res) begin
                res_data  <= {cord_sin, cord_cos};
                res_valid <= 1'b1;
                cnt_done  <= cnt_done + 1'b1;
            end else if (ack) begin
                res_valid <= 1'b0;
            end
            if (wr_en && wr_full)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
        end
    end

`ifdef CORDIC_REQ_TIMEOUT_EN
    // Counter sits at zero outside WAIT, so every entry to WAIT starts a fresh count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state != WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (to_fire)
                timeout <= 1'b1;
            else if (clr_err)
                timeout <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule
